// File: rtl/sdram_cmd_arbiter_pkg.sv
// Shared SDRAM definitions for the command arbiter: command codes, bus widths and FSM states.
package sdram_cmd_arbiter_pkg;

  localparam int SDRAM_ASIZE = 13;
  localparam int SDRAM_BSIZE = 2;

  // Command encoding is {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_MSET = 4'b0000;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_WR   = 4'b0100;
  localparam logic [3:0] C_RD   = 4'b0101;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_cmd_arbiter_ref_timer.sv
// Periodic auto-refresh timer: raises a sticky refresh request every REF_PERIOD cycles.
module sdram_ref_timer #(
  parameter int REF_PERIOD = 750,
  parameter int REF_CNT_W  = 10
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_aref_end,
  output logic o_ref_req
);

  logic [REF_CNT_W-1:0] r_cnt;
  logic                 r_ref_req;
  logic                 w_wrap;

  assign w_wrap    = i_run && (r_cnt == REF_CNT_W'(REF_PERIOD - 1));
  assign o_ref_req = r_ref_req;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_ref_req <= 1'b0;
    end else begin
      if (i_run) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
      // A wrap wins over a simultaneous completion so the new period is not lost
      if (w_wrap) begin
        r_ref_req <= 1'b1;
      end else if (i_aref_end) begin
        r_ref_req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command arbiter: owns the command pins after init and grants refresh/write/read engines in turn.
module sdram_cmd_arbiter
  import sdram_cmd_arbiter_pkg::*;
#(
  parameter int ASIZE      = SDRAM_ASIZE,
  parameter int BSIZE      = SDRAM_BSIZE,
  parameter int REF_PERIOD = 750,
  parameter int REF_CNT_W  = 10
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic [3:0]       init_cmd,
  input  logic [ASIZE-1:0] init_addr,
  input  logic             init_done,
  output logic             ref_req,
  output logic             aref_en,
  input  logic             aref_end,
  input  logic [3:0]       aref_cmd,
  input  logic [ASIZE-1:0] aref_addr,
  input  logic             wr_req,
  output logic             wr_en,
  input  logic             wr_end,
  input  logic [3:0]       wr_cmd,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [BSIZE-1:0] wr_ba,
  input  logic             rd_req,
  output logic             rd_en,
  input  logic             rd_end,
  input  logic [3:0]       rd_cmd,
  input  logic [ASIZE-1:0] rd_addr,
  input  logic [BSIZE-1:0] rd_ba,
  output logic [3:0]       sdram_cmd,
  output logic [ASIZE-1:0] sdram_addr,
  output logic [BSIZE-1:0] sdram_ba,
  output logic             init_ok
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_aref_en;
  logic       r_wr_en;
  logic       r_rd_en;
  logic       r_init_ok;
  logic       w_ref_req;
  logic       w_grant_aref;
  logic       w_grant_wr;
  logic       w_grant_rd;

  sdram_ref_timer #(
    .REF_PERIOD(REF_PERIOD),
    .REF_CNT_W (REF_CNT_W)
  ) u_ref_timer (
    .clk_100m  (clk_100m),
    .rst_n     (rst_n),
    .i_run     (r_init_ok),
    .i_aref_end(aref_end),
    .o_ref_req (w_ref_req)
  );

  assign ref_req = w_ref_req;
  assign aref_en = r_aref_en;
  assign wr_en   = r_wr_en;
  assign rd_en   = r_rd_en;
  assign init_ok = r_init_ok;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_aref = 1'b0;
    w_grant_wr   = 1'b0;
    w_grant_rd   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (init_done) w_state_nxt = ST_IDLE;
      end
      // Grants only happen from IDLE, which guarantees an idle cycle between operations
      ST_IDLE: begin
        if (w_ref_req) begin
          w_state_nxt  = ST_AREF;
          w_grant_aref = 1'b1;
        end else if (wr_req) begin
          w_state_nxt = ST_WRITE;
          w_grant_wr  = 1'b1;
        end else if (rd_req) begin
          w_state_nxt = ST_READ;
          w_grant_rd  = 1'b1;
        end
      end
      ST_AREF: begin
        if (aref_end) w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        if (wr_end) w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (rd_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_init_ok <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aref_en <= w_grant_aref;
      r_wr_en   <= w_grant_wr;
      r_rd_en   <= w_grant_rd;
      if ((r_state == ST_INIT) && init_done) r_init_ok <= 1'b1;
    end
  end

  // Pin mux follows the registered owner with no extra pipeline delay
  always_comb begin
    sdram_cmd  = C_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    case (r_state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_ba;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_ba;
      end
      default: begin
        sdram_cmd  = C_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Randomized bench for sdram_cmd_arbiter against a cycle-level ownership model.
module tb_sdram_cmd_arbiter;

  localparam int ASIZE = 13;
  localparam int BSIZE = 2;
  localparam int REF   = 750;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;

  // Who owns the SDRAM pins in the reference model
  localparam int O_INIT = 0;
  localparam int O_IDLE = 1;
  localparam int O_AREF = 2;
  localparam int O_WR   = 3;
  localparam int O_RD   = 4;

  logic             clk_100m = 1'b0;
  logic             rst_n;
  logic [3:0]       init_cmd;
  logic [ASIZE-1:0] init_addr;
  logic             init_done;
  logic             ref_req;
  logic             aref_en;
  logic             aref_end;
  logic [3:0]       aref_cmd;
  logic [ASIZE-1:0] aref_addr;
  logic             wr_req;
  logic             wr_en;
  logic             wr_end;
  logic [3:0]       wr_cmd;
  logic [ASIZE-1:0] wr_addr;
  logic [BSIZE-1:0] wr_ba;
  logic             rd_req;
  logic             rd_en;
  logic             rd_end;
  logic [3:0]       rd_cmd;
  logic [ASIZE-1:0] rd_addr;
  logic [BSIZE-1:0] rd_ba;
  logic [3:0]       sdram_cmd;
  logic [ASIZE-1:0] sdram_addr;
  logic [BSIZE-1:0] sdram_ba;
  logic             init_ok;

  sdram_cmd_arbiter #(
    .ASIZE(ASIZE), .BSIZE(BSIZE), .REF_PERIOD(REF), .REF_CNT_W(10)
  ) dut (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_done(init_done),
    .ref_req(ref_req), .aref_en(aref_en), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .init_ok(init_ok)
  );

  always #5 clk_100m = ~clk_100m;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int         m_own;
  bit         m_ok;
  bit         m_pend;
  int         m_on;
  logic [2:0] m_en;

  // Stimulus controls
  bit         g_rst, g_idone, g_rand, g_force_wr, g_force_rd;
  int         g_wr_hold, g_rd_hold;
  logic [2:0] g_obs_en;

  task automatic model_reset();
    m_own = O_INIT; m_ok = 0; m_pend = 0; m_on = 0; m_en = 3'b000;
  endtask

  task automatic model_step();
    int  nown;
    bit  wrap;
    logic [2:0] nen;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nown = m_own;
    nen  = 3'b000;
    case (m_own)
      O_INIT: if (init_done) nown = O_IDLE;
      O_IDLE: begin
        if (m_pend)      begin nown = O_AREF; nen = 3'b100; end
        else if (wr_req) begin nown = O_WR;   nen = 3'b010; end
        else if (rd_req) begin nown = O_RD;   nen = 3'b001; end
      end
      O_AREF: if (aref_end) nown = O_IDLE;
      O_WR:   if (wr_end)   nown = O_IDLE;
      O_RD:   if (rd_end)   nown = O_IDLE;
      default: nown = O_INIT;
    endcase
    // Refresh due once every REF cycles of operation counted from init completion
    wrap = m_ok && ((m_on % REF) == REF - 1);
    if (m_ok) m_on++;
    if (wrap) m_pend = 1;
    else if (aref_end) m_pend = 0;
    if (m_own == O_INIT && init_done) m_ok = 1;
    m_own = nown;
    m_en  = nen;
  endtask

  task automatic drive_inputs();
    rst_n     = !g_rst;
    init_done = g_idone;
    init_cmd  = PRE;
    init_addr = ASIZE'($urandom);
    aref_cmd  = 4'($urandom);  aref_addr = ASIZE'($urandom);
    wr_cmd    = 4'($urandom);  wr_addr   = ASIZE'($urandom); wr_ba = BSIZE'($urandom);
    rd_cmd    = 4'($urandom);  rd_addr   = ASIZE'($urandom); rd_ba = BSIZE'($urandom);
    aref_end  = (m_own == O_AREF) && ($urandom_range(0, 3) == 0);
    if (m_own == O_WR) begin
      if (g_wr_hold > 0) begin wr_end = 0; g_wr_hold--; end
      else wr_end = ($urandom_range(0, 3) == 0);
    end else wr_end = g_rand && ($urandom_range(0, 15) == 0);
    if (m_own == O_RD) begin
      if (g_rd_hold > 0) begin rd_end = 0; g_rd_hold--; end
      else rd_end = ($urandom_range(0, 3) == 0);
    end else rd_end = g_rand && ($urandom_range(0, 15) == 0);
    if (m_own == O_WR) wr_req = 0;
    else if (g_force_wr) wr_req = 1;
    else if (g_rand) wr_req = wr_req ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 5) == 0);
    else wr_req = 0;
    if (m_own == O_RD) rd_req = 0;
    else if (g_force_rd) rd_req = 1;
    else if (g_rand) rd_req = rd_req ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 5) == 0);
    else rd_req = 0;
  endtask

  task automatic compare_all();
    logic [3:0]       e_cmd;
    logic [ASIZE-1:0] e_addr;
    logic [BSIZE-1:0] e_ba;
    e_cmd = NOP; e_addr = '0; e_ba = '0;
    case (m_own)
      O_INIT: begin e_cmd = init_cmd; e_addr = init_addr; end
      O_AREF: begin e_cmd = aref_cmd; e_addr = aref_addr; end
      O_WR:   begin e_cmd = wr_cmd; e_addr = wr_addr; e_ba = wr_ba; end
      O_RD:   begin e_cmd = rd_cmd; e_addr = rd_addr; e_ba = rd_ba; end
      default: ;
    endcase
    chk("sdram_cmd",  32'(sdram_cmd),  32'(e_cmd));
    chk("sdram_addr", 32'(sdram_addr), 32'(e_addr));
    chk("sdram_ba",   32'(sdram_ba),   32'(e_ba));
    chk("grants",     32'({aref_en, wr_en, rd_en}), 32'(m_en));
    chk("ref_req",    32'(ref_req),    32'(m_pend));
    chk("init_ok",    32'(init_ok),    32'(m_ok));
    g_obs_en = {aref_en, wr_en, rd_en};
  endtask

  task automatic step();
    @(negedge clk_100m);
    drive_inputs();
    if (!rst_n) model_reset();
    #1;
    compare_all();
    model_step();
  endtask

  task automatic wait_grant(input int max, output logic [2:0] got, output int n);
    got = 3'b000;
    n   = 0;
    while (got == 3'b000 && n < max) begin
      step();
      n++;
      got = g_obs_en;
    end
  endtask

  // Release reset, pulse init_done on cycle 20, then expect the first refresh 751 cycles after init_ok
  task automatic do_init(input string tag);
    logic [2:0] got;
    int n;
    g_rst = 0;
    for (int i = 1; i <= 20; i++) begin
      g_idone = (i == 20);
      step();
    end
    g_idone = 0;
    step();
    chk({tag, "_init_ok"}, 32'(init_ok), 32'd1);
    chk({tag, "_nop"}, 32'(sdram_cmd), 32'(NOP));
    wait_grant(800, got, n);
    chk({tag, "_aref_grant"}, 32'(got), 32'b100);
    chk({tag, "_aref_latency"}, 32'(n), 32'(REF + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] got;
    int n;
    g_rst = 1; g_idone = 0; g_rand = 0; g_force_wr = 0; g_force_rd = 0;
    g_wr_hold = 0; g_rd_hold = 0; g_obs_en = 0;
    wr_req = 0; rd_req = 0;
    model_reset();
    drive_inputs();

    // Reset state
    for (int i = 0; i < 3; i++) step();
    chk("rst_grants", 32'({aref_en, wr_en, rd_en}), 32'd0);
    chk("rst_init_ok", 32'(init_ok), 32'd0);
    chk("rst_cmd_tracks_init", 32'(sdram_cmd), 32'(PRE));

    // Init handover and first refresh
    do_init("p1");
    for (int i = 0; i < 20; i++) step();

    // Simultaneous write and read requests: write first, read after an idle cycle
    g_force_wr = 1; g_force_rd = 1;
    wait_grant(20, got, n);
    chk("p3_first_wr", 32'(got), 32'b010);
    g_force_wr = 0;
    wait_grant(40, got, n);
    chk("p3_then_rd", 32'(got), 32'b001);
    g_force_rd = 0;
    for (int i = 0; i < 20; i++) step();

    // Long write spanning two refresh periods with a read waiting: single refresh wins next
    g_wr_hold = 1600; g_force_wr = 1;
    wait_grant(20, got, n);
    chk("p4_wr_grant", 32'(got), 32'b010);
    g_force_wr = 0; g_force_rd = 1;
    n = 0;
    while (g_wr_hold > 0 && n < 1700) begin step(); n++; end
    chk("p4_ref_pending", 32'(ref_req), 32'd1);
    wait_grant(60, got, n);
    chk("p4_aref_wins", 32'(got), 32'b100);
    wait_grant(60, got, n);
    chk("p5_rd_after_one_aref", 32'(got), 32'b001);
    g_force_rd = 0;

    // Randomized traffic
    g_rand = 1;
    for (int i = 0; i < 3000; i++) step();
    g_rand = 0;
    for (int i = 0; i < 30; i++) step();

    // Reset during a read
    g_rd_hold = 6; g_force_rd = 1;
    wait_grant(100, got, n);
    chk("p6_rd_grant", 32'(got), 32'b001);
    g_force_rd = 0;
    step(); step();
    g_rst = 1;
    step();
    chk("p6_init_ok", 32'(init_ok), 32'd0);
    chk("p6_cmd_init", 32'(sdram_cmd), 32'(init_cmd));
    chk("p6_rd_en", 32'(rd_en), 32'd0);
    step(); step();
    g_rd_hold = 0;
    do_init("p6");
    for (int i = 0; i < 10; i++) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
